muldiv_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit in the EX stage, beside the ALU. Takes the same

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes; sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q;
  logic [4:0]         count_q;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic               sign_a_q, sign_b_q, is_div_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op, neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] step_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, in1_raw;

  always_comb begin
    signed_op = (op[2] == 1'b0) && (op[0] == 1'b0);
    neg1      = signed_op & in1[WIDTH-1];
    neg2      = signed_op & in2[WIDTH-1];
    mag1      = neg1 ? -in1 : in1;
    mag2      = neg2 ? -in2 : in2;

    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    // Partial remainder needs one extra bit: 2*rem+1 can exceed WIDTH bits for large divisors.
    div_part  = work_q[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_part} - {2'b00, opb_q};

    if (is_div_q) begin
      if (div_diff[WIDTH+1]) begin
        step_d = {div_part[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
      end else begin
        step_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_d = {mul_sum, work_q[WIDTH-1:1]};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    // Original dividend rebuilt from magnitude and sign for the divide-by-zero result.
    in1_raw  = sign_a_q ? -opa_q : opa_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= 5'd0;
      work_q   <= {(2*WIDTH){1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              case (op)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                  opa_q    <= mag1;
                  opb_q    <= mag2;
                  sign_a_q <= neg1;
                  sign_b_q <= neg2;
                  is_div_q <= op[1];
                  work_q   <= op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
                  count_q  <= 5'd0;
                  state_q  <= StRun;
                  busy_q   <= 1'b1;
                end
                3'b100:  hi_q <= in1;
                3'b101:  lo_q <= in1;
                default: ;
              endcase
            end
          end
          StRun: begin
            work_q  <= step_d;
            count_q <= count_q + 5'd1;
            if (count_q == 5'd31) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            if (is_div_q) begin
              if (opb_q == {WIDTH{1'b0}}) begin
                lo_q <= {WIDTH{1'b1}};
                hi_q <= in1_raw;
              end else begin
                lo_q <= quot_fix;
                hi_q <= rem_fix;
              end
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] in1 = 32'h0;
  logic [31:0] in2 = 32'h0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One start pulse sampled on a single rising edge; returns just after that edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    issue(o, a, b);
    wait_done(n);
    check({tag, " busy_cycles"}, n, 32'd33);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;

    #12;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'b100, 32'h1234_5678, 32'h0);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi busy", {31'b0, busy}, 32'd0);
    check("mthi done", {31'b0, done}, 32'd0);
    issue(3'b101, 32'h9ABC_DEF0, 32'h0);
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi", hi, 32'h1234_5678);

    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nop busy", {31'b0, busy}, 32'd0);
    check("nop hi", hi, 32'h1234_5678);
    check("nop lo", lo, 32'h9ABC_DEF0);

    run_op("mult_m3x5",   3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_m3xm4",  3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C);
    run_op("multu_max",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7d2",    3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",    3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf",     3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_by0",    3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_m7by0",   3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_d16",    3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("divu_bigdiv", 3'b011, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001);

    // Flush on the 10th RUN cycle leaves the preloaded HI/LO untouched.
    issue(3'b100, 32'hAAAA_AAAA, 32'h0);
    issue(3'b101, 32'h5555_5555, 32'h0);
    issue(3'b011, 32'd100, 32'd7);
    check("flush busy_before", {31'b0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush done", {31'b0, done}, 32'd0);
    check("flush hi", hi, 32'hAAAA_AAAA);
    check("flush lo", lo, 32'h5555_5555);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("flush no_done", seen, 32'd0);
    check("flush hi_later", hi, 32'hAAAA_AAAA);

    // Flush beats a same-edge MTHI.
    @(negedge clk);
    start = 1'b1;
    op    = 3'b100;
    in1   = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_mthi hi", hi, 32'hAAAA_AAAA);
    check("flush_mthi busy", {31'b0, busy}, 32'd0);

    // A second start while busy is ignored.
    issue(3'b001, 32'd7, 32'd6);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 3'b010;
    in1   = 32'd100;
    in2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("restart busy_cycles", n, 32'd27);
    check("restart done", {31'b0, done}, 32'd1);
    check("restart hi", hi, 32'h0);
    check("restart lo", lo, 32'd42);

    // Asynchronous reset mid-RUN.
    issue(3'b100, 32'h1111_1111, 32'h0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst hi", hi, 32'h0);
    check("arst lo", lo, 32'h0);
    check("arst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst busy_after", {31'b0, busy}, 32'd0);
    check("arst done_after", {31'b0, done}, 32'd0);
    run_op("post_rst", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
